uart_alu_bridge: RTL

Parametrised successor to the byte-wide UART/ALU interface. It assembles a multi-byte command frame from the UART receiver: one opcode byte, then operand A, then operand B, each NB_DATA/8 bytes, LSB first. It drives the combinational ALU, captures the NB_DATA-bit result and streams it back through the UART transmitter, one byte per tx handshake. It adds inter-byte timeout and opcode validation that the byte-wide version lacks, and sits between uart_rx/uart_tx and alu in the top level.

---
 rtl/uart_alu_bridge.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: assembles an opcode + two NB_DATA-bit operands from UART
// bytes (LSB first), drives the ALU, and streams the result back one byte per
// transmitter handshake. Adds inter-byte timeout and opcode validation.
// Optional feature macro: UART_ALU_BRIDGE_ERR_RESP_EN -- when defined, errors
// (bad opcode or timeout) also transmit a single 0xEE byte.
module uart_alu_bridge #(
    parameter int unsigned NB_DATA        = 16,
    parameter int unsigned NB_ALU_OP      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_data_out,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    output logic [NB_ALU_OP-1:0] o_alu_op,
    output logic [NB_DATA-1:0]   o_alu_data_A,
    output logic [NB_DATA-1:0]   o_alu_data_B,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned NBYTES   = NB_DATA / 8;
    localparam int unsigned IDXW     = $clog2(NBYTES) + 1;
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    // Counter holds (cycles since last byte - 1); the decision is taken one
    // edge early so the registered o_err lands exactly TIMEOUT_CYCLES later.
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES < 2) ? 0 : TIMEOUT_CYCLES - 2;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);
    localparam logic [7:0]      OP_MASK  = 8'((1 << NB_ALU_OP) - 1);
    localparam logic [7:0]      ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_TX_LOAD,
        S_TX_WAIT,
        S_ERR
    } state_t;

    state_t               r_state;
    logic [IDXW-1:0]      r_idx;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [NB_ALU_OP-1:0] r_alu_op;
    logic [NB_DATA-1:0]   r_data_a;
    logic [NB_DATA-1:0]   r_data_b;
    logic [NB_DATA-1:0]   r_result;
    logic [7:0]           r_tx_data;
    logic                 r_tx_start;
    logic                 r_busy;
    logic                 r_err;

    logic w_op_ok;
    logic w_in_rx;
    logic w_tmo_hit;

    // Select byte lane idx of a data word.
    function automatic logic [7:0] byte_sel(input logic [NB_DATA-1:0] v,
                                            input logic [IDXW-1:0]    idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (idx == IDXW'(i)) b = v[i*8 +: 8];
        end
        return b;
    endfunction

    // Replace byte lane idx of a data word.
    function automatic logic [NB_DATA-1:0] lane_write(input logic [NB_DATA-1:0] v,
                                                      input logic [IDXW-1:0]    idx,
                                                      input logic [7:0]         d);
        logic [NB_DATA-1:0] r;
        r = v;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (idx == IDXW'(i)) r[i*8 +: 8] = d;
        end
        return r;
    endfunction

    // Opcode check, receive-phase flag and timeout expiry (a byte always wins).
    always_comb begin
        w_op_ok   = (i_rx_data & ~OP_MASK) == 8'h00;
        w_in_rx   = (r_state == S_RX_A) || (r_state == S_RX_B);
        w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_in_rx && !i_rx_done &&
                    (r_tmo_cnt == TMO_W'(TMO_LAST));
    end

    // Inter-byte timeout counter; cleared by any byte, any state change, or outside RX.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tmo_cnt <= '0;
        end else if ((TIMEOUT_CYCLES != 0) && w_in_rx && !i_rx_done && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Frame assembly, execute and transmit sequencing with registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_alu_op   <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            if (w_tmo_hit) begin
                // Partial frame is discarded; opcode/operands keep their values.
                r_err <= 1'b1;
                r_idx <= '0;
`ifdef UART_ALU_BRIDGE_ERR_RESP_EN
                r_state    <= S_ERR;
                r_tx_data  <= ERR_BYTE;
                r_tx_start <= 1'b1;
`else
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_rx_done) begin
                            r_busy <= 1'b1;
                            if (w_op_ok) begin
                                r_alu_op <= i_rx_data[NB_ALU_OP-1:0];
                                r_data_a <= '0;
                                r_data_b <= '0;
                                r_idx    <= '0;
                                r_state  <= S_RX_A;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
`ifdef UART_ALU_BRIDGE_ERR_RESP_EN
                                r_tx_data  <= ERR_BYTE;
                                r_tx_start <= 1'b1;
`endif
                            end
                        end
                    end
                    S_RX_A: begin
                        if (i_rx_done) begin
                            r_data_a <= lane_write(r_data_a, r_idx, i_rx_data);
                            if (r_idx == IDX_LAST) begin
                                r_idx   <= '0;
                                r_state <= S_RX_B;
                            end else begin
                                r_idx <= r_idx + IDXW'(1);
                            end
                        end
                    end
                    S_RX_B: begin
                        if (i_rx_done) begin
                            r_data_b <= lane_write(r_data_b, r_idx, i_rx_data);
                            if (r_idx == IDX_LAST) begin
                                r_idx   <= '0;
                                r_state <= S_EXEC;
                            end else begin
                                r_idx <= r_idx + IDXW'(1);
                            end
                        end
                    end
                    S_EXEC: begin
                        // First result byte is taken straight from the ALU while it is captured.
                        r_result   <= i_alu_data_out;
                        r_tx_data  <= i_alu_data_out[7:0];
                        r_tx_start <= 1'b1;
                        r_idx      <= '0;
                        r_state    <= S_TX_LOAD;
                    end
                    S_TX_LOAD: begin
                        r_state <= S_TX_WAIT;
                    end
                    S_TX_WAIT: begin
                        if (i_tx_done) begin
                            if (r_idx == IDX_LAST) begin
                                r_idx   <= '0;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_idx      <= r_idx + IDXW'(1);
                                r_tx_data  <= byte_sel(r_result, r_idx + IDXW'(1));
                                r_tx_start <= 1'b1;
                                r_state    <= S_TX_LOAD;
                            end
                        end
                    end
                    S_ERR: begin
`ifdef UART_ALU_BRIDGE_ERR_RESP_EN
                        if (i_tx_done) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`else
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_alu_op     = r_alu_op;
    assign o_alu_data_A = r_data_a;
    assign o_alu_data_B = r_data_b;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule
